// File: rtl/sample_buffer_ctrl.sv
// Capture/playback sequencer and host-read arbiter for the single-port sample RAM.
// Define SBC_PLAY_LOOP_EN to make playback wrap to PLAY_START forever instead of stopping in DONE.
//
// state    | meaning
// IDLE     | waiting for start
// ARM      | waiting for the first nonzero sample
// CAPTURE  | one write every DECIM cycles until DEPTH samples stored
// PLAYBACK | one read every PLAY_DIV cycles from PLAY_START up to DEPTH-1
// DONE     | playback finished, LED nibble held, start re-arms
module sample_buffer_ctrl #(
   parameter int DATA_W     = 8,
   parameter int ADDR_W     = 16,
   parameter int DEPTH      = 50000,
   parameter int DECIM      = 97,
   parameter int PLAY_DIV   = 1000000,
   parameter int PLAY_START = 49000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [DATA_W-1:0] sample_in,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              host_req,
   input  logic [ADDR_W-1:0] host_addr,
   output logic              host_ack,
   output logic              host_rvalid,
   output logic [DATA_W-1:0] host_rdata,
   output logic [3:0]        play_data,
   output logic              play_valid,
   output logic [2:0]        state,
   output logic              done
);

   localparam int DEC_W  = $clog2(DECIM);
   localparam int PLAY_W = $clog2(PLAY_DIV);

   localparam logic [DEC_W-1:0]  DEC_LAST   = DEC_W'(DECIM - 1);
   localparam logic [PLAY_W-1:0] PLAY_LAST  = PLAY_W'(PLAY_DIV - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] ADDR_PLAY0 = ADDR_W'(PLAY_START);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_ARM      = 3'd1,
      S_CAPTURE  = 3'd2,
      S_PLAYBACK = 3'd3,
      S_DONE     = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [DEC_W-1:0]  dec_cnt_q, dec_cnt_d;
   logic [PLAY_W-1:0] play_cnt_q, play_cnt_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic              fsm_wr, fsm_rd;
   logic              play_valid_q, host_rvalid_q, done_q;
   logic [3:0]        play_hold_q;
   logic [DATA_W-1:0] host_hold_q;

   assign fsm_wr = (state_q == S_CAPTURE)  && (dec_cnt_q == DEC_LAST);
   assign fsm_rd = (state_q == S_PLAYBACK) && (play_cnt_q == PLAY_LAST);

   // FSM access always wins; the host only gets otherwise idle RAM cycles
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      host_ack  = 1'b0;
      if (fsm_wr) begin
         mem_en    = 1'b1;
         mem_we    = 1'b1;
         mem_addr  = wr_ptr_q;
         mem_wdata = sample_in;
      end else if (fsm_rd) begin
         mem_en   = 1'b1;
         mem_addr = rd_ptr_q;
      end else if (host_req) begin
         mem_en   = 1'b1;
         mem_addr = host_addr;
         host_ack = 1'b1;
      end
   end

   always_comb begin
      state_d    = state_q;
      dec_cnt_d  = dec_cnt_q;
      play_cnt_d = play_cnt_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      if (abort) begin
         state_d    = S_IDLE;
         dec_cnt_d  = '0;
         play_cnt_d = '0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state_d    = S_ARM;
                  dec_cnt_d  = '0;
                  play_cnt_d = '0;
                  wr_ptr_d   = '0;
                  rd_ptr_d   = '0;
               end
            end
            S_ARM: begin
               if (sample_in != '0) state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
               if (fsm_wr) begin
                  dec_cnt_d = '0;
                  wr_ptr_d  = wr_ptr_q + ADDR_W'(1);
                  if (wr_ptr_q == ADDR_LAST) begin
                     state_d    = S_PLAYBACK;
                     play_cnt_d = '0;
                     rd_ptr_d   = ADDR_PLAY0;
                  end
               end else begin
                  dec_cnt_d = dec_cnt_q + DEC_W'(1);
               end
            end
            S_PLAYBACK: begin
               if (fsm_rd) begin
                  play_cnt_d = '0;
                  if (rd_ptr_q == ADDR_LAST) begin
`ifdef SBC_PLAY_LOOP_EN
                     rd_ptr_d = ADDR_PLAY0;
`else
                     state_d  = S_DONE;
`endif
                  end else begin
                     rd_ptr_d = rd_ptr_q + ADDR_W'(1);
                  end
               end else begin
                  play_cnt_d = play_cnt_q + PLAY_W'(1);
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // read strobes follow the issue even through abort, so in-flight data still lands
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         dec_cnt_q     <= '0;
         play_cnt_q    <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         play_valid_q  <= 1'b0;
         host_rvalid_q <= 1'b0;
         done_q        <= 1'b0;
         play_hold_q   <= '0;
         host_hold_q   <= '0;
      end else begin
         state_q       <= state_d;
         dec_cnt_q     <= dec_cnt_d;
         play_cnt_q    <= play_cnt_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         play_valid_q  <= fsm_rd;
         host_rvalid_q <= host_ack;
         done_q        <= (state_d == S_DONE);
         if (play_valid_q)  play_hold_q <= mem_rdata[3:0];
         if (host_rvalid_q) host_hold_q <= mem_rdata;
      end
   end

   // RAM data is passed through during the valid cycle and held afterwards,
   // keeping the one-cycle read latency on both data paths
   assign play_data   = play_valid_q  ? mem_rdata[3:0] : play_hold_q;
   assign host_rdata  = host_rvalid_q ? mem_rdata      : host_hold_q;
   assign play_valid  = play_valid_q;
   assign host_rvalid = host_rvalid_q;
   assign state       = state_q;
   assign done        = done_q;

endmodule

// File: tb/tb_sample_buffer_ctrl.sv
// Scoreboard bench for sample_buffer_ctrl: a RAM model, a timing-formula reference
// that queues expected writes/reads/results, and a negedge monitor that checks them.
module tb_sample_buffer_ctrl;
   localparam int DATA_W     = 8;
   localparam int ADDR_W     = 4;
   localparam int DEPTH      = 8;
   localparam int DECIM      = 4;
   localparam int PLAY_DIV   = 3;
   localparam int PLAY_START = 2;
`ifdef SBC_PLAY_LOOP_EN
   localparam bit LOOP = 1'b1;
`else
   localparam bit LOOP = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst, start, abort;
   logic [DATA_W-1:0] sample_in;
   logic              mem_en, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              host_req;
   logic [ADDR_W-1:0] host_addr;
   logic              host_ack, host_rvalid;
   logic [DATA_W-1:0] host_rdata;
   logic [3:0]        play_data;
   logic              play_valid;
   logic [2:0]        state;
   logic              done;

   sample_buffer_ctrl #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .DECIM(DECIM),
      .PLAY_DIV(PLAY_DIV), .PLAY_START(PLAY_START)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .sample_in(sample_in),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .host_req(host_req), .host_addr(host_addr),
      .host_ack(host_ack), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
      .play_data(play_data), .play_valid(play_valid), .state(state), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int a;
      int d;
      int c;
   } ev_t;

   ev_t  wq[$];
   ev_t  rq[$];
   ev_t  pq[$];
   int   hq[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   last_ack = -10;
   ev_t  me;
   logic [DATA_W-1:0] ram [2**ADDR_W];
   logic [DATA_W-1:0] mem_model [DEPTH];

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else        mem_rdata     <= ram[mem_addr];
      end
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (host_req && last_ack == cyc - 1) host_req = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (host_rvalid) begin
            check("host_rv_expected", int'(hq.size() > 0), 1);
            if (hq.size() > 0) check("host_rdata", int'(host_rdata), hq.pop_front());
            check("host_rv_cyc", cyc, last_ack + 1);
         end
         if (mem_en && mem_we) begin
            check("wr_expected", int'(wq.size() > 0), 1);
            if (wq.size() > 0) begin
               me = wq.pop_front();
               check("wr_addr", int'(mem_addr), me.a);
               check("wr_data", int'(mem_wdata), me.d);
               check("wr_cyc", cyc, me.c);
            end
            check("wr_no_host_ack", int'(host_ack), 0);
         end
         if (mem_en && !mem_we && !host_ack) begin
            check("rd_expected", int'(rq.size() > 0), 1);
            if (rq.size() > 0) begin
               me = rq.pop_front();
               check("rd_addr", int'(mem_addr), me.a);
               check("rd_cyc", cyc, me.c);
            end
         end
         if (host_ack) begin
            check("ack_mem_ctrl", int'({mem_en, mem_we}), 2);
            check("ack_addr", int'(mem_addr), int'(host_addr));
            last_ack = cyc;
         end
         if (play_valid) begin
            check("play_expected", int'(pq.size() > 0), 1);
            if (pq.size() > 0) begin
               me = pq.pop_front();
               check("play_data", int'(play_data), me.d);
               check("play_cyc", cyc, me.c);
            end
         end
      end
   end

   task automatic check_outputs_zero(input string tag);
      check({tag, "_ctrl"}, int'({mem_en, mem_we, host_ack, host_rvalid, play_valid, done, state}), 0);
      check({tag, "_data"}, int'({mem_addr, mem_wdata, host_rdata, play_data}), 0);
   endtask

   // abort_rd >= 0: abort in the cycle after that playback read is issued
   task automatic run_once(input bit do_host, input int abort_rd);
      int   t0, p0, nrd, tgt, hreq;
      bit   do_abort;
      logic [DATA_W-1:0] s;
      ev_t  e;
      hreq = -1;
      start = 1'b1;
      sample_in = '0;
      step();
      start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         check("arm_hold", int'(state), 1);
         step();
      end
      sample_in = 8'h05;
      check("arm_hold", int'(state), 1);
      step();
      check("capture_entry", int'(state), 2);
      t0 = cyc;
      for (int k = 0; k < DEPTH; k++) begin
         for (int j = 0; j < DECIM; j++) begin
            s = DATA_W'($urandom);
            sample_in = s;
            start = (k == 3 && j == 1);
            if (j == DECIM - 1) begin
               e.a = k;
               e.d = int'(s);
               e.c = t0 + DECIM - 1 + k * DECIM;
               wq.push_back(e);
               if (do_host && k == 1) begin
                  host_req  = 1'b1;
                  host_addr = ADDR_W'(5);
                  hq.push_back(int'(mem_model[5]));
                  hreq = cyc;
               end
               mem_model[k] = s;
            end
            step();
         end
      end
      start = 1'b0;
      check("playback_entry", int'(state), 3);
      p0 = cyc;
      if (do_host) check("host_ack_after_write", last_ack, hreq + 1);
      do_abort = (abort_rd >= 0) || LOOP;
      nrd = (abort_rd >= 0) ? abort_rd + 1 : (LOOP ? 20 : DEPTH - PLAY_START);
      for (int i = 0; i < nrd; i++) begin
         e.a = PLAY_START + i % (DEPTH - PLAY_START);
         e.d = 0;
         e.c = p0 + PLAY_DIV - 1 + i * PLAY_DIV;
         rq.push_back(e);
         e.d = int'(mem_model[e.a] & 8'h0f);
         e.c = p0 + (i + 1) * PLAY_DIV;
         pq.push_back(e);
      end
      tgt = p0 + nrd * PLAY_DIV;
      while (cyc < tgt) begin
         check("play_state", int'(state), 3);
         check("done_low", int'(done), 0);
         step();
      end
      if (do_abort) begin
         abort = 1'b1;
         start = 1'b1;
         step();
         abort = 1'b0;
         start = 1'b0;
         check("abort_idle", int'(state), 0);
         check("abort_done", int'(done), 0);
      end else begin
         check("done_state", int'(state), 4);
         check("done_flag", int'(done), 1);
         step();
         step();
         check("play_hold", int'(play_data), int'(mem_model[DEPTH-1] & 8'h0f));
         check("done_stays", int'(state), 4);
      end
   endtask

   initial begin
      int hreq, a;
      rst = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      sample_in = '0;
      host_req = 1'b0;
      host_addr = '0;
      step();
      step();
      step();
      check_outputs_zero("reset");
      rst = 1'b0;
      step();

      start = 1'b1;
      sample_in = 8'h05;
      step();
      start = 1'b0;
      check("pre_arm", int'(state), 1);
      step();
      check("pre_capture", int'(state), 2);
      step();
      rst = 1'b1;
      step();
      check_outputs_zero("mid_capture_reset");
      rst = 1'b0;

      run_once(1'b0, -1);

      for (int n = 0; n < 3; n++) begin
         a = int'($urandom_range(0, DEPTH - 1));
         host_req  = 1'b1;
         host_addr = ADDR_W'(a);
         hq.push_back(int'(mem_model[a]));
         hreq = cyc;
         step();
         check("host_ack_idle", last_ack, hreq);
         step();
         check("host_rdata_hold", int'(host_rdata), int'(mem_model[a]));
      end

      run_once(1'b1, 1);
      run_once(1'b0, -1);

      step();
      step();
      check("wq_drained", wq.size(), 0);
      check("rq_drained", rq.size(), 0);
      check("pq_drained", pq.size(), 0);
      check("hq_drained", hq.size(), 0);
      check("host_req_released", int'(host_req), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
